// File: rtl/fifo_burst_pkg.sv
// Shared constants and helpers for the FIFO burst reader and its skid buffer.
package fifo_burst_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam int SKID_DEPTH = 2;

  // A programmed burst length of zero behaves as a single-word burst.
  function automatic int unsigned len_or_one(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO show-ahead read port plus the outgoing valid/ready stream of the burst reader.
interface fifo_burst_reader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [ADDR_WIDTH-1:0] fifo_used;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_re;

  // Stream: a word transfers on a rising edge where out_valid and out_ready are
  // both high; once raised, out_valid/out_data/out_last hold until that transfer.
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    input  fifo_empty, fifo_used, fifo_rdata, out_ready,
    output fifo_re, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_used, fifo_rdata, out_ready,
    input  fifo_re, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_burst_reader_skid.sv
// Two-entry registered buffer of {last, data}; the head entry drives the stream.
module burst_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  output logic [1:0]            count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);
  logic [DATA_WIDTH-1:0] head_data, tail_data;
  logic                  head_last, tail_last;
  logic                  pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = head_data;
  assign out_last  = head_last;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= push_data;
            head_last <= push_last;
          end else begin
            tail_data <= push_data;
            tail_last <= push_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (count == 2'd1) begin
            head_data <= push_data;
            head_last <= push_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= push_data;
            tail_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO into fixed-length bursts, flushing partial bursts on timeout.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TMO_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] burst_len,
  input  logic [TMO_WIDTH-1:0]  timeout,
  fifo_burst_reader_if.master   bus,
  output logic                  busy,
  output logic [15:0]           burst_count,
  output logic [0:0]            fsm_state
);
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [TMO_WIDTH-1:0]  tmo_cnt;
  logic [ADDR_WIDTH-1:0] len_eff;
  logic [1:0]            skid_count;
  logic                  start_full, start_tmo;

  assign len_eff    = ADDR_WIDTH'(len_or_one(32'(burst_len)));
  assign start_full = enable && (bus.fifo_used >= len_eff);
  assign start_tmo  = enable && !bus.fifo_empty && (bus.fifo_used < burst_len) &&
                      (timeout != '0) && (tmo_cnt == timeout - TMO_WIDTH'(1));

  // Pop decision depends only on registered state, never on out_ready.
  assign bus.fifo_re = (state == ST_BURST) && !bus.fifo_empty &&
                       (skid_count < 2'(SKID_DEPTH));
  assign busy        = (state != ST_IDLE) || (skid_count != 2'd0);
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      tmo_cnt     <= '0;
      burst_count <= 16'd0;
    end else if (state == ST_IDLE) begin
      if (start_full) begin
        state     <= ST_BURST;
        remaining <= len_eff;
        tmo_cnt   <= '0;
      end else if (start_tmo) begin
        state     <= ST_BURST;
        // fifo_used may still read zero while the empty flag has already cleared.
        remaining <= (bus.fifo_used == '0) ? ADDR_WIDTH'(1) : bus.fifo_used;
        tmo_cnt   <= '0;
      end else if (enable && !bus.fifo_empty) begin
        tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end else begin
      tmo_cnt <= '0;
      if (bus.fifo_re) begin
        remaining <= remaining - ADDR_WIDTH'(1);
        if (remaining == ADDR_WIDTH'(1)) begin
          state       <= ST_IDLE;
          burst_count <= burst_count + 16'd1;
        end
      end
    end
  end

  burst_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.fifo_re),
    .push_data (bus.fifo_rdata),
    .push_last (remaining == ADDR_WIDTH'(1)),
    .count     (skid_count),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .out_last  (bus.out_last)
  );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural show-ahead FIFO, stream scoreboard, scenario tasks.
module tb_fifo_burst_reader;
  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  burst_len;
  logic [15:0] timeout;
  logic        busy;
  logic [15:0] burst_count;
  logic [0:0]  fsm_state;

  fifo_burst_reader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  fifo_burst_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TMO_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .burst_len   (burst_len),
    .timeout     (timeout),
    .bus         (bus),
    .busy        (busy),
    .burst_count (burst_count),
    .fsm_state   (fsm_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] fifo_q[$];
  logic [8:0] exp_q[$];
  int         pop_cyc[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pop_cnt = 0, hs_cnt = 0, last_cnt = 0, max_ahead = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  task automatic update_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_used  = (fifo_q.size() > 15) ? 4'd15 : 4'(fifo_q.size());
    bus.fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic fifo_write(input logic [7:0] d);
    fifo_q.push_back(d);
    update_fifo();
  endtask

  // One clock: sample just before the edge, apply FIFO pop and score handshakes after it.
  task automatic tick();
    logic       re_now, v, hs, l;
    logic [7:0] d;
    logic [8:0] e;
    #1;
    re_now = bus.fifo_re;
    v      = bus.out_valid;
    hs     = v && bus.out_ready;
    d      = bus.out_data;
    l      = bus.out_last;
    if (prev_stall && !reset) begin
      n_cmp++;
      if (v !== 1'b1 || d !== prev_data || l !== prev_last) begin
        n_bad++;
        $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 v, d, l, prev_data, prev_last);
      end
    end
    prev_stall = v && !bus.out_ready && !reset;
    prev_data  = d;
    prev_last  = l;
    @(posedge clk);
    #1;
    cyc++;
    if (re_now) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pop_cnt++;
      pop_cyc.push_back(cyc);
    end
    if (hs && !reset) begin
      hs_cnt++;
      if (l) last_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_word: got data=%h last=%b, required no output", d, l);
      end else begin
        e = exp_q.pop_front();
        if ({l, d} !== e) begin
          n_bad++;
          $display("FAIL stream_word: got last=%b data=%h, required last=%b data=%h",
                   l, d, e[8], e[7:0]);
        end
      end
    end
    if (pop_cnt - hs_cnt > max_ahead) max_ahead = pop_cnt - hs_cnt;
    update_fifo();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    tick();
    reset = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    pop_cyc.delete();
    update_fifo();
    pop_cnt = 0; hs_cnt = 0; last_cnt = 0; max_ahead = 0;
    prev_stall = 1'b0;
  endtask

  task automatic load_packets(input int n, input int len, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_write(base + 8'(i));
      exp_q.push_back({((i % len) == len - 1), base + 8'(i)});
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || busy); i++) tick();
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL drain: %0d words outstanding busy=%b, required 0 and busy=0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; burst_len = 4'd4; timeout = 16'd0;
    bus.out_ready = 1'b1;
    update_fifo();
    tick(); tick();
    n_cmp++;
    if (bus.fifo_re !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.out_last !== 1'b0 || busy !== 1'b0 || burst_count !== 16'd0 || fsm_state !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: re=%b valid=%b data=%h last=%b busy=%b count=%0d state=%b, required all 0",
               bus.fifo_re, bus.out_valid, bus.out_data, bus.out_last, busy, burst_count, fsm_state);
    end
    reset = 1'b0;
  endtask

  task automatic test_full_bursts();
    do_reset();
    burst_len = 4'd4; timeout = 16'd0; bus.out_ready = 1'b1;
    load_packets(8, 4, 8'h10);
    enable = 1'b1;
    drain(60);
    n_cmp++;
    if (burst_count !== 16'd2 || last_cnt != 2) begin
      n_bad++;
      $display("FAIL full_count: bursts=%0d lasts=%0d, required 2 and 2", burst_count, last_cnt);
    end
    n_cmp++;
    if (pop_cyc.size() != 8) begin
      n_bad++;
      $display("FAIL full_pops: %0d pops, required 8", pop_cyc.size());
    end else if (pop_cyc[3] - pop_cyc[0] != 3 || pop_cyc[4] - pop_cyc[3] != 2) begin
      n_bad++;
      $display("FAIL full_gap: span=%0d gap=%0d, required span 3 gap 2",
               pop_cyc[3] - pop_cyc[0], pop_cyc[4] - pop_cyc[3]);
    end
  endtask

  task automatic test_timeout_flush();
    int n;
    do_reset();
    burst_len = 4'd8; timeout = 16'd20; bus.out_ready = 1'b1;
    enable = 1'b1;
    load_packets(3, 3, 8'h40);
    n = 0;
    while (fsm_state !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != 20) begin
      n_bad++;
      $display("FAIL timeout_delay: burst started after %0d cycles, required 20", n);
    end
    drain(40);
    n_cmp++;
    if (burst_count !== 16'd1 || last_cnt != 1) begin
      n_bad++;
      $display("FAIL timeout_count: bursts=%0d lasts=%0d, required 1 and 1", burst_count, last_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    burst_len = 4'd4; timeout = 16'd0;
    load_packets(8, 4, 8'h60);
    enable = 1'b1;
    for (int i = 0; i < 120 && (exp_q.size() != 0 || busy); i++) begin
      bus.out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    bus.out_ready = 1'b1;
    drain(20);
    n_cmp++;
    if (max_ahead > 2 || burst_count !== 16'd2 || hs_cnt != 8) begin
      n_bad++;
      $display("FAIL bp_totals: ahead=%0d bursts=%0d words=%0d, required ahead<=2 bursts=2 words=8",
               max_ahead, burst_count, hs_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    burst_len = 4'd4; timeout = 16'd0; bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_write(8'h80 + 8'(i));
    enable = 1'b1;
    for (int i = 0; i < 20 && pop_cnt < 2; i++) tick();
    tick(); tick();
    n_cmp++;
    if (pop_cnt != 2 || bus.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_prefill: pops=%0d valid=%b, required 2 and 1", pop_cnt, bus.out_valid);
    end
    reset = 1'b1;
    enable = 1'b0;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || burst_count !== 16'd0 || fsm_state !== 1'b0 ||
        busy !== 1'b0 || bus.out_last !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: valid=%b count=%0d state=%b busy=%b last=%b, required 0",
               bus.out_valid, burst_count, fsm_state, busy, bus.out_last);
    end
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (hs_cnt != 0 || last_cnt != 0) begin
      n_bad++;
      $display("FAIL mid_discard: words=%0d lasts=%0d, required 0 and 0", hs_cnt, last_cnt);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    burst_len = 4'd4; timeout = 16'd0; bus.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      fifo_write(8'hA0 + 8'(i));
      if (i < 4) exp_q.push_back({(i == 3), 8'hA0 + 8'(i)});
    end
    enable = 1'b1;
    for (int i = 0; i < 20 && pop_cnt < 1; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    n_cmp++;
    if (hs_cnt != 4 || burst_count !== 16'd1 || fifo_q.size() != 10 || fsm_state !== 1'b0) begin
      n_bad++;
      $display("FAIL enable_drop: words=%0d bursts=%0d left=%0d state=%b, required 4 1 10 0",
               hs_cnt, burst_count, fifo_q.size(), fsm_state);
    end
  endtask

  task automatic test_no_timeout();
    do_reset();
    burst_len = 4'd6; timeout = 16'd0; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) fifo_write(8'hC0 + 8'(i));
    enable = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    n_cmp++;
    if (hs_cnt != 0 || burst_count !== 16'd0 || pop_cnt != 0) begin
      n_bad++;
      $display("FAIL no_timeout: words=%0d bursts=%0d pops=%0d, required 0", hs_cnt, burst_count, pop_cnt);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back({(i == 5), 8'hC0 + 8'(i)});
    fifo_write(8'hC5);
    drain(40);
    n_cmp++;
    if (burst_count !== 16'd1 || last_cnt != 1) begin
      n_bad++;
      $display("FAIL sixth_word: bursts=%0d lasts=%0d, required 1 and 1", burst_count, last_cnt);
    end
  endtask

  task automatic test_len_zero();
    do_reset();
    burst_len = 4'd0; timeout = 16'd0; bus.out_ready = 1'b1;
    load_packets(2, 1, 8'hE0);
    enable = 1'b1;
    drain(30);
    n_cmp++;
    if (burst_count !== 16'd2 || last_cnt != 2) begin
      n_bad++;
      $display("FAIL len_zero: bursts=%0d lasts=%0d, required 2 and 2", burst_count, last_cnt);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; burst_len = 4'd4; timeout = 16'd0;
    bus.out_ready = 1'b1;
    update_fifo();
    test_reset();
    test_full_bursts();
    test_timeout_flush();
    test_backpressure();
    test_reset_mid_burst();
    test_enable_drop();
    test_no_timeout();
    test_len_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
